// File: rtl/johnson_step_sequencer.sv
// Command-driven sequencer for a WIDTH-stage Johnson phase register.
// Accepts a move (steps, direction, period) over valid/ready and steps once per period.
module johnson_step_sequencer #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8,
   parameter int DIV_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_dir,
   input  logic [CNT_W-1:0] cmd_steps,
   input  logic [DIV_W-1:0] cmd_period,
   input  logic             abort,
   output logic [WIDTH-1:0] phase,
   output logic             busy,
   output logic [CNT_W-1:0] steps_left,
   output logic             done,
   output logic             aborted
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_phase;
   logic [WIDTH-1:0] w_phase_nxt;
   logic             r_dir;
   logic             w_dir_nxt;
   logic [DIV_W-1:0] r_period;
   logic [DIV_W-1:0] w_period_nxt;
   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] w_div_nxt;
   logic [CNT_W-1:0] r_steps;
   logic [CNT_W-1:0] w_steps_nxt;
   logic             r_done;
   logic             w_done_nxt;
   logic             r_aborted;
   logic             w_aborted_nxt;
   logic             w_accept;

   function automatic logic [WIDTH-1:0] f_step_fwd(input logic [WIDTH-1:0] p);
      return {~p[0], p[WIDTH-1:1]};
   endfunction

   function automatic logic [WIDTH-1:0] f_step_rev(input logic [WIDTH-1:0] p);
      return {p[WIDTH-2:0], ~p[WIDTH-1]};
   endfunction

   // Ready is withheld for the whole time reset is asserted.
   assign cmd_ready = (r_state == S_IDLE) && !reset;
   assign w_accept  = cmd_valid && cmd_ready;

   always_comb begin
      w_state_nxt   = r_state;
      w_phase_nxt   = r_phase;
      w_dir_nxt     = r_dir;
      w_period_nxt  = r_period;
      w_div_nxt     = r_div;
      w_steps_nxt   = r_steps;
      w_done_nxt    = 1'b0;
      w_aborted_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_dir_nxt    = cmd_dir;
               w_period_nxt = cmd_period;
               w_div_nxt    = cmd_period;
               w_steps_nxt  = cmd_steps;
               if (cmd_steps == '0) begin
                  w_done_nxt = 1'b1;
               end else begin
                  w_state_nxt = S_RUN;
               end
            end
         end
         S_RUN: begin
            // Abort wins over a step due on the same edge.
            if (abort) begin
               w_state_nxt   = S_IDLE;
               w_done_nxt    = 1'b1;
               w_aborted_nxt = 1'b1;
            end else if (r_div != '0) begin
               w_div_nxt = r_div - DIV_W'(1);
            end else begin
               w_phase_nxt = r_dir ? f_step_rev(r_phase) : f_step_fwd(r_phase);
               w_steps_nxt = r_steps - CNT_W'(1);
               w_div_nxt   = r_period;
               if (r_steps == CNT_W'(1)) begin
                  w_state_nxt = S_IDLE;
                  w_done_nxt  = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_phase   <= '0;
         r_dir     <= 1'b0;
         r_period  <= '0;
         r_div     <= '0;
         r_steps   <= '0;
         r_done    <= 1'b0;
         r_aborted <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_phase   <= w_phase_nxt;
         r_dir     <= w_dir_nxt;
         r_period  <= w_period_nxt;
         r_div     <= w_div_nxt;
         r_steps   <= w_steps_nxt;
         r_done    <= w_done_nxt;
         r_aborted <= w_aborted_nxt;
      end
   end

   assign phase      = r_phase;
   assign busy       = (r_state == S_RUN);
   assign steps_left = r_steps;
   assign done       = r_done;
   assign aborted    = r_aborted;

endmodule
